// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives pc into instr_mem and buffers {pc, instruction}
// in a 2-entry prefetch queue feeding decode. Optional macro: IFETCH_HALT_ON_ZERO_EN.
module instr_fetch #(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] pc,
  input  logic [15:0] instruction,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic        halted
);

  logic [15:0] pc_reg;
  logic [1:0]  count_reg;
  logic [1:0]  count_next;
  logic [15:0] q_pc_reg    [2];
  logic [15:0] q_instr_reg [2];
  logic        pop;
  logic        push;
  logic [1:0]  load_new;
  logic [1:0]  load_shift;

  assign pc       = pc_reg;
  assign if_valid = (count_reg != 2'd0);
  assign if_pc    = q_pc_reg[0];
  assign if_instr = q_instr_reg[0];

  always_comb begin
    pop         = if_valid && if_ready;
    push        = !halted && !redirect_valid && ((count_reg < 2'd2) || pop);
    load_new    = 2'b00;
    load_shift  = 2'b00;
    count_next  = count_reg;
    // Slot 0 is always the head; slot 1 only shifts forward when the head leaves a full queue.
    load_new[0]   = push && ((count_reg == 2'd0) || ((count_reg == 2'd1) && pop));
    load_new[1]   = push && (((count_reg == 2'd1) && !pop) || ((count_reg == 2'd2) && pop));
    load_shift[0] = pop && (count_reg == 2'd2);
    if (redirect_valid) begin
      count_next = 2'd0;
    end else begin
      count_next = count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg    <= PC_RESET;
      count_reg <= 2'd0;
    end else begin
      count_reg <= count_next;
      if (redirect_valid) begin
        pc_reg <= redirect_pc & 16'hFFFE;
      end else if (push) begin
        pc_reg <= pc_reg + 16'd2;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_pc_reg[gi]    <= 16'h0000;
          q_instr_reg[gi] <= 16'h0000;
        end else if (load_new[gi]) begin
          q_pc_reg[gi]    <= pc_reg;
          q_instr_reg[gi] <= instruction;
        end else if (load_shift[gi]) begin
          q_pc_reg[gi]    <= q_pc_reg[(gi + 1) % 2];
          q_instr_reg[gi] <= q_instr_reg[(gi + 1) % 2];
        end
      end
    end
  endgenerate

`ifdef IFETCH_HALT_ON_ZERO_EN
  logic halted_reg;

  // A zero word is still enqueued; only further fetches stop until a redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_reg <= 1'b0;
    end else if (redirect_valid) begin
      halted_reg <= 1'b0;
    end else if (push && (instruction == 16'h0000)) begin
      halted_reg <= 1'b1;
    end
  end

  assign halted = halted_reg;
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized
// ready/redirect traffic compared against a queue-based reference model.
module tb_instr_fetch;

  localparam logic [15:0] PC_RESET = 16'h0000;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc;
  logic [15:0] instruction;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        halted;

  int checks = 0;
  int errors = 0;

  logic [15:0] imem [16];
  logic [15:0] m_pc;
  logic        m_halted;
  logic [31:0] m_q [$];

  instr_fetch #(.PC_RESET(PC_RESET)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc             (pc),
    .instruction    (instruction),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a < 16'd32) return imem[a[4:1]];
    return 16'h0000;
  endfunction

  assign instruction = mem_word(pc);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc     = PC_RESET;
    m_halted = 1'b0;
  endtask

  task automatic model_compare(input string tag);
    chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, m_q.size() != 0});
    chk({tag, ".pc"}, {16'd0, pc}, {16'd0, m_pc});
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, m_halted});
    if (m_q.size() != 0) chk({tag, ".head"}, {if_pc, if_instr}, m_q[0]);
  endtask

  // Advance one clock: compare, drive inputs, update the model with the rules of the stage.
  task automatic step(input logic rdy, input logic rv, input logic [15:0] rpc, input string tag);
    logic [15:0] w;
    logic        p_pop;
    logic        p_push;
    model_compare(tag);
    if_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    w      = mem_word(m_pc);
    p_pop  = (m_q.size() != 0) && rdy;
    p_push = !m_halted && !rv && ((m_q.size() < 2) || p_pop);
    if (p_pop) void'(m_q.pop_front());
    if (rv) begin
      m_q.delete();
      m_pc     = rpc & 16'hFFFE;
      m_halted = 1'b0;
    end else if (p_push) begin
      m_q.push_back({m_pc, w});
      m_pc = m_pc + 16'd2;
`ifdef IFETCH_HALT_ON_ZERO_EN
      if (w == 16'h0000) m_halted = 1'b1;
`endif
    end
    @(posedge clk);
    @(negedge clk);
    $display("step %s rdy=%0b rv=%0b rpc=%h -> pc=%h valid=%0b if_pc=%h if_instr=%h halted=%0b",
             tag, rdy, rv, rpc, pc, if_valid, if_pc, if_instr, halted);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst.valid", {31'd0, if_valid}, 32'd0);
    chk("rst.instr", {16'd0, if_instr}, 32'd0);
    chk("rst.ifpc", {16'd0, if_pc}, 32'd0);
    chk("rst.pc", {16'd0, pc}, {16'd0, PC_RESET});
    chk("rst.halted", {31'd0, halted}, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    imem[0] = 16'h8180; imem[1] = 16'h2CB2; imem[2] = 16'h1A05;
    imem[3] = 16'h4C31; imem[4] = 16'h3003; imem[5] = 16'hF0F6;
    imem[6] = 16'h0000;
    for (int i = 7; i < 16; i++) imem[i] = 16'h5000 + 16'(i);

    // Reset and stream
    do_reset();
    step(1'b1, 1'b0, 16'h0, "stream0");
    chk("stream.first", {if_pc, if_instr}, {16'h0000, 16'h8180});
    step(1'b1, 1'b0, 16'h0, "stream1");
    chk("stream.second", {if_pc, if_instr}, {16'h0002, 16'h2CB2});
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, "stream");

    // Redirect with pop at steady state
    step(1'b1, 1'b1, 16'h0003, "redir");
    chk("redir.pc", {16'd0, pc}, 32'h0002);
    chk("redir.valid", {31'd0, if_valid}, 32'd0);
    step(1'b1, 1'b0, 16'h0, "redir1");
    chk("redir.head", {if_pc, if_instr}, {16'h0002, 16'h2CB2});

`ifndef IFETCH_HALT_ON_ZERO_EN
    // Wrap-around
    step(1'b1, 1'b1, 16'hFFFE, "wrap");
    step(1'b1, 1'b0, 16'h0, "wrap1");
    chk("wrap.a", {if_pc, if_instr}, {16'hFFFE, 16'h0000});
    step(1'b1, 1'b0, 16'h0, "wrap2");
    chk("wrap.b", {if_pc, if_instr}, {16'h0000, 16'h8180});
`endif

    // Backpressure
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 16'h0, "bp");
    chk("bp.pc", {16'd0, pc}, 32'h0004);
    chk("bp.valid", {31'd0, if_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("bp.order", {16'd0, if_pc}, 32'(i * 2));
      step(1'b1, 1'b0, 16'h0, "bpdrain");
    end

`ifdef IFETCH_HALT_ON_ZERO_EN
    // Halt on zero word
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 16'h0, "halt");
    chk("halt.halted", {31'd0, halted}, 32'd1);
    chk("halt.pc", {16'd0, pc}, 32'h000E);
    chk("halt.valid", {31'd0, if_valid}, 32'd0);
    step(1'b1, 1'b1, 16'h0000, "unhalt");
    step(1'b1, 1'b0, 16'h0, "unhalt1");
    chk("unhalt.head", {if_pc, if_instr}, {16'h0000, 16'h8180});
    chk("unhalt.halted", {31'd0, halted}, 32'd0);
`endif

    // Async reset mid-stream with a full queue
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, "fill");
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", {31'd0, if_valid}, 32'd0);
    chk("arst.pc", {16'd0, pc}, {16'd0, PC_RESET});
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 16'h0, "arst0");
    chk("arst.restart", {if_pc, if_instr}, {16'h0000, 16'h8180});

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic        rdy;
      logic        rv;
      logic [15:0] tgt;
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 19) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
      step(rdy, rv, tgt, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the 16-bit core. Drives the byte-address `pc` into `instr_mem`, captures the combinational `instruction` it returns, and buffers `{pc, instruction}` pairs in a 2-entry prefetch queue. The queue feeds decode through a valid/ready handshake. Decode or execute can redirect the stream (branch/jump), which flushes the queue and restarts fetch at the target.

## Interface
- `PC_RESET`, default `16'h0000`: fetch address after reset.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `pc`  out  16: fetch address to `instr_mem`; bit 0 always 0.
- `instruction`  in  16: word returned by `instr_mem` for the current `pc`, same cycle.
- `redirect_valid`  in  1: load a new fetch target this cycle.
- `redirect_pc`  in  16: target address; bit 0 ignored (forced 0).
- `if_valid`  out  1: queue head is valid.
- `if_ready`  in  1: decode accepts the head.
- `if_instr`  out  16: head instruction.
- `if_pc`  out  16: address of the head instruction.
- `halted`  out  1: fetch stopped (see Configuration).

## Operation
- **Queue**
  - 2-entry FIFO of `{pc, instruction}` with a count of 0..2.
  - `if_valid` = (count != 0); `if_instr` and `if_pc` come from the head entry.
- **Pop:** `if_valid && if_ready`.
- **Push:** `!halted && !redirect_valid && (count < 2 || pop)`.
  - Writes `{pc, instruction}` at the tail.
  - `pc <= pc + 2`, modulo 2^16, so `16'hFFFE` wraps to `16'h0000`.
- **Simultaneous push and pop**
  - With count 2: count stays 2, head advances, new entry is written at the tail.
  - With count 1: count stays 1, new entry becomes the head.
- **Redirect** has priority over push in the same cycle.
  - Any pop in that cycle still completes; decode discards it.
  - Next cycle: count = 0, `pc = {redirect_pc[15:1], 1'b0}`, `halted = 0`.
- **No stall:** while the queue is full and `if_ready` is low, `pc` holds and `instruction` is ignored.
- Addresses at or above 32 return `16'h0000` from `instr_mem`. The fetch unit treats that word as data unless the halt feature is compiled in.

## Timing
- **Reset values:** `pc = PC_RESET`, count 0, `if_valid = 0`, `if_instr = 16'h0000`, `if_pc = 16'h0000`, `halted = 0`.
- **Startup:** the first push happens on the first rising edge after `rst_n` deasserts. `if_valid` is high one cycle later.
- **Redirect latency:** `redirect_valid` in cycle N gives `pc = target` in N+1 and `if_valid` with `if_pc = target` in N+2.
- **Throughput:** one instruction per cycle while `if_ready` is held high.
- **Reset mid-operation:** asynchronous.
  - All state returns to reset values immediately.
  - Queue contents are lost.
  - No partial entries are presented after release.
- **Paths:**
  - `if_*` outputs are registered or driven from the registered FIFO head; no combinational path from `if_ready` or `redirect_*` to them.
  - `pc` is a register.

## Configuration
- Macro: `IFETCH_HALT_ON_ZERO_EN`.
- **Defined**
  - A pushed `instruction == 16'h0000` is enqueued normally and sets `halted` on the same edge.
  - While `halted`, no pushes occur and `pc` holds the address after the zero word.
  - The queue still drains to decode.
  - Only `redirect_valid` or reset clears `halted`.
- **Undefined**
  - `16'h0000` is fetched like any other word.
  - `halted` is tied to 0.

## Test plan
- **Reset and stream:** `instr_mem` holds the standard 6-word loop. `if_ready = 1`, release reset.
  - Cycle 2 shows `if_pc = 0x0000`, `if_instr = 0x8180`.
  - Cycle 3 shows `if_pc = 0x0002`, `if_instr = 0x2CB2`.
  - One entry per cycle after that.
- **Backpressure:** hold `if_ready = 0` for 5 cycles after reset.
  - Count saturates at 2 and `pc` holds at `0x0004`.
  - Raise `if_ready`: entries come out in order 0x0000, 0x0002, 0x0004 with no loss or duplicates.
- **Redirect with pop:** at steady state, assert `redirect_valid` with `redirect_pc = 0x0003` while `if_ready = 1`.
  - Next cycle: `pc = 0x0002`, `if_valid = 0`.
  - Following cycle: `if_pc = 0x0002`, `if_instr = 0x2CB2`.
- **Wrap-around:** redirect to `0xFFFE`.
  - Entries follow with `if_pc` 0xFFFE, `instr 0x0000`, then 0x0000, `instr 0x8180`.
  - Run without `IFETCH_HALT_ON_ZERO_EN`.
- **Halt (macro defined):** run from reset.
  - The fetch of `0x000C` (`16'h0000`) sets `halted = 1`, and `pc` stays at `0x000E`.
  - Remaining entries drain, then `if_valid = 0`.
  - Redirect to `0x0000` clears `halted` and restarts at `0x8180`.
- **Async reset mid-stream:** pull `rst_n` low between edges while count = 2.
  - `if_valid = 0` and `pc = PC_RESET` immediately.
  - After release, the stream restarts from `0x0000`.
